// File: rtl/fp_result_deser.sv
// fp_result_deser
//   Downstream stage of the FP multiplier. Reassembles the byte-serial
//   double-precision product (8 bytes, LSB first, qualified by BYTE_VLD)
//   into 64-bit words. Each word goes into a show-ahead FIFO that hands words
//   to the consumer with a RES_VALID/RES_ACCEPT handshake. Head words are
//   optionally classified per IEEE-754.
//
// Configuration macro:
//   FP_CLASSIFY_EN  defined   -> RES_CLASS decodes the head word
//                   undefined -> RES_CLASS tied to 0 (no classifier logic)
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   BYTE_VLD        byte strobe (multiplier READY)
//   BYTE_IN[7:0]    product byte (multiplier DATA_OUT)
//   RES_ACCEPT      consumer takes the head word this cycle
//   RES_VALID       FIFO non-empty
//   RES_DATA[63:0]  head word (0 when empty)
//   RES_SIGN        bit 63 of head word
//   RES_CLASS[2:0]  0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN
//   COUNT           occupied FIFO entries
//   FRAME_ERR       sticky: a partial frame was aborted
//   OVERFLOW        sticky: a complete word was dropped on a full FIFO
module fp_result_deser #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     BYTE_VLD,
  input  logic [7:0]               BYTE_IN,
  input  logic                     RES_ACCEPT,
  output logic                     RES_VALID,
  output logic [63:0]              RES_DATA,
  output logic                     RES_SIGN,
  output logic [2:0]               RES_CLASS,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FRAME_ERR,
  output logic                     OVERFLOW
);

  localparam int AW = $clog2(DEPTH);

  logic [2:0]  bcnt;
  logic [55:0] asm_reg;
  logic [63:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic [63:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push  = BYTE_VLD && (bcnt == 3'd7);
  assign pop   = RES_ACCEPT && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bcnt      <= '0;
      asm_reg   <= '0;
      wptr      <= '0;
      rptr      <= '0;
      FRAME_ERR <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (BYTE_VLD) begin
        if (bcnt == 3'd7) begin
          bcnt <= '0;
        end else begin
          asm_reg[{bcnt, 3'b000} +: 8] <= BYTE_IN;
          bcnt                         <= bcnt + 3'd1;
        end
      end else if (bcnt != 3'd0) begin
        bcnt      <= '0;
        asm_reg   <= '0;
        FRAME_ERR <= 1'b1;
      end

      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (push && !wr_en) begin
        OVERFLOW <= 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage is not reset; pointers alone define occupancy.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_en) begin
      mem[wptr[AW-1:0]] <= {BYTE_IN, asm_reg};
    end
  end

  assign head      = empty ? '0 : mem[rptr[AW-1:0]];
  assign RES_VALID = !empty;
  assign RES_DATA  = head;
  assign RES_SIGN  = head[63];
  assign COUNT     = wptr - rptr;

`ifdef FP_CLASSIFY_EN
  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUBNRM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } fp_class_e;

  fp_class_e   cls;
  logic [10:0] exp_f;
  logic [51:0] man_f;

  assign exp_f = head[62:52];
  assign man_f = head[51:0];

  always_comb begin
    cls = CLS_ZERO;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? CLS_ZERO : CLS_SUBNRM;
    end else if (exp_f == '1) begin
      if (man_f == '0)
        cls = CLS_INF;
      else if (man_f[51])
        cls = CLS_QNAN;
      else
        cls = CLS_SNAN;
    end else begin
      cls = CLS_NORMAL;
    end
  end

  assign RES_CLASS = cls;
`else
  assign RES_CLASS = 3'd0;
`endif

endmodule

// File: tb/tb_fp_result_deser.sv
module tb_fp_result_deser;

  logic        CLK;
  logic        RESET;
  logic        BYTE_VLD;
  logic [7:0]  BYTE_IN;
  logic        RES_ACCEPT;
  logic        RES_VALID;
  logic [63:0] RES_DATA;
  logic        RES_SIGN;
  logic [2:0]  RES_CLASS;
  logic [2:0]  COUNT;
  logic        FRAME_ERR;
  logic        OVERFLOW;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fp_result_deser #(.DEPTH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BYTE_VLD   (BYTE_VLD),
    .BYTE_IN    (BYTE_IN),
    .RES_ACCEPT (RES_ACCEPT),
    .RES_VALID  (RES_VALID),
    .RES_DATA   (RES_DATA),
    .RES_SIGN   (RES_SIGN),
    .RES_CLASS  (RES_CLASS),
    .COUNT      (COUNT),
    .FRAME_ERR  (FRAME_ERR),
    .OVERFLOW   (OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected class for the current build; hand-derived field tests.
  function automatic logic [2:0] exp_cls(input logic [63:0] w);
    logic [2:0] c;
    if (w[62:52] == 11'h000)
      c = (w[51:0] == 52'd0) ? 3'd0 : 3'd1;
    else if (w[62:52] == 11'h7FF)
      c = (w[51:0] == 52'd0) ? 3'd3 : (w[51] ? 3'd4 : 3'd5);
    else
      c = 3'd2;
`ifdef FP_CLASSIFY_EN
    return c;
`else
    return (c == 3'd7) ? 3'd1 : 3'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    BYTE_VLD = 1'b1;
    BYTE_IN  = b;
    tick();
  endtask

  // Sends one full frame; RES_ACCEPT optionally high during the 8th byte.
  task automatic send_word(input logic [63:0] w, input bit acc_last);
    logic [63:0] tmp;
    tmp = w;
    for (int i = 0; i < 7; i++) send_byte(tmp[8*i +: 8]);
    RES_ACCEPT = acc_last;
    send_byte(tmp[63:56]);
    RES_ACCEPT = 1'b0;
    BYTE_VLD   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_valid"}, 64'(RES_VALID), 64'd0);
    check({pfx, "_data"},  RES_DATA,       64'd0);
    check({pfx, "_sign"},  64'(RES_SIGN),  64'd0);
    check({pfx, "_class"}, 64'(RES_CLASS), 64'd0);
    check({pfx, "_count"}, 64'(COUNT),     64'd0);
    check({pfx, "_ferr"},  64'(FRAME_ERR), 64'd0);
    check({pfx, "_ovf"},   64'(OVERFLOW),  64'd0);
  endtask

  logic [63:0] q4 [4];
  logic [2:0]  c4 [4];
  logic [63:0] w6;

  initial begin
    RESET = 1'b1; BYTE_VLD = 1'b0; BYTE_IN = 8'h00; RES_ACCEPT = 1'b0;
    q4[0] = 64'h7FF0000000000000; c4[0] = 3'd3;
    q4[1] = 64'h7FF8000000000000; c4[1] = 3'd4;
    q4[2] = 64'h7FF0000000000001; c4[2] = 3'd5;
    q4[3] = 64'h0000000000000001; c4[3] = 3'd1;
    do_reset();
    check_reset_state("rst");

    // 6.0: bytes 00 00 00 00 00 00 18 40, zero extra latency
    w6 = 64'h4018000000000000;
    for (int i = 0; i < 7; i++) send_byte(w6[8*i +: 8]);
    check("six_not_yet", 64'(RES_VALID), 64'd0);
    send_byte(8'h40);
    BYTE_VLD = 1'b0;
    check("six_valid", 64'(RES_VALID), 64'd1);
    check("six_data",  RES_DATA, 64'h4018000000000000);
    check("six_class", 64'(RES_CLASS), 64'(exp_cls(64'h4018000000000000)));
    check("six_sign",  64'(RES_SIGN), 64'd0);
    check("six_count", 64'(COUNT), 64'd1);
    RES_ACCEPT = 1'b1;
    tick();
    RES_ACCEPT = 1'b0;
    check("six_pop_valid", 64'(RES_VALID), 64'd0);
    check("six_pop_data",  RES_DATA, 64'd0);
    // accept while empty is ignored
    RES_ACCEPT = 1'b1;
    tick();
    RES_ACCEPT = 1'b0;
    check("empty_acc_count", 64'(COUNT), 64'd0);

    // four back-to-back frames, then overflow with no pop
    for (int i = 0; i < 4; i++) send_word(q4[i], 1'b0);
    check("fill_count", 64'(COUNT), 64'd4);
    check("fill_ovf",   64'(OVERFLOW), 64'd0);
    send_word(64'h3FF0000000000000, 1'b0);
    check("ovf_flag",  64'(OVERFLOW), 64'd1);
    check("ovf_count", 64'(COUNT), 64'd4);
    check("ovf_head",  RES_DATA, q4[0]);
    RES_ACCEPT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop%0d_data", i),  RES_DATA, q4[i]);
      check($sformatf("pop%0d_class", i), 64'(RES_CLASS), 64'(exp_cls(q4[i])));
      check($sformatf("pop%0d_count", i), 64'(COUNT), 64'(4 - i));
      tick();
    end
    RES_ACCEPT = 1'b0;
    check("drain_valid", 64'(RES_VALID), 64'd0);
    check("ovf_sticky",  64'(OVERFLOW), 64'd1);

    // full FIFO, pop coincides with the 8th byte: word accepted
    do_reset();
    for (int i = 0; i < 4; i++) send_word(q4[i], 1'b0);
    send_word(64'h3FF0000000000000, 1'b1);
    check("fpop_ovf",   64'(OVERFLOW), 64'd0);
    check("fpop_count", 64'(COUNT), 64'd4);
    check("fpop_head",  RES_DATA, q4[1]);
    RES_ACCEPT = 1'b1;
    tick(); tick(); tick();
    RES_ACCEPT = 1'b0;
    check("fpop_last_data",  RES_DATA, 64'h3FF0000000000000);
    check("fpop_last_class", 64'(RES_CLASS), 64'(exp_cls(64'h3FF0000000000000)));
    check("fpop_last_count", 64'(COUNT), 64'd1);

    // aborted frame then -0.0
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    BYTE_VLD = 1'b0;
    tick();
    check("abort_ferr",  64'(FRAME_ERR), 64'd1);
    check("abort_count", 64'(COUNT), 64'd0);
    send_word(64'h8000000000000000, 1'b0);
    check("negz_count", 64'(COUNT), 64'd1);
    check("negz_data",  RES_DATA, 64'h8000000000000000);
    check("negz_sign",  64'(RES_SIGN), 64'd1);
    check("negz_class", 64'(RES_CLASS), 64'd0);
    check("negz_ferr",  64'(FRAME_ERR), 64'd1);

    // reset mid-frame with two words queued, reset beats BYTE_VLD/RES_ACCEPT
    send_word(64'h3FF0000000000000, 1'b0);
    check("pre_rst_count", 64'(COUNT), 64'd2);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    RESET = 1'b1; BYTE_VLD = 1'b1; RES_ACCEPT = 1'b1;
    tick();
    RESET = 1'b0; BYTE_VLD = 1'b0; RES_ACCEPT = 1'b0;
    check_reset_state("midrst");
    send_word(64'h7FF0000000000000, 1'b0);
    check("post_rst_count", 64'(COUNT), 64'd1);
    check("post_rst_data",  RES_DATA, 64'h7FF0000000000000);
    check("post_rst_sign",  64'(RES_SIGN), 64'd0);
    check("post_rst_class", 64'(RES_CLASS), 64'(exp_cls(64'h7FF0000000000000)));
    check("post_rst_ferr",  64'(FRAME_ERR), 64'd0);

    // push and pop together on a non-full, non-empty FIFO
    send_word(64'hC000000000000000, 1'b1);
    check("pp_count", 64'(COUNT), 64'd1);
    check("pp_data",  RES_DATA, 64'hC000000000000000);
    check("pp_sign",  64'(RES_SIGN), 64'd1);
    check("pp_class", 64'(RES_CLASS), 64'(exp_cls(64'hC000000000000000)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
